// File: rtl/lut_arbiter_pkg.sv
// Shared types and helpers for the colour-LUT arbiter.
package lut_arb_pkg;

  typedef logic [23:0] rgb_t;

  localparam rgb_t RGB_BLACK = 24'h000000;

  // Iteration counts at or beyond the table depth belong to the set and render black.
  function automatic logic clamp_inside(input logic [63:0] iter, input logic [63:0] max);
    return (iter >= max);
  endfunction

endpackage

// File: rtl/lut_arbiter_if.sv
// Engine request bus, shared-LUT lookup port and pixel output stream of the arbiter.
interface lut_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RBG_SIZE   = 24,
  parameter int TAG_WIDTH  = 20
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ*DATA_WIDTH-1:0] req_iter;
  logic [N_REQ*TAG_WIDTH-1:0]  req_tag;
  logic [DATA_WIDTH-1:0]       lut_iter;
  logic [RBG_SIZE-1:0]         lut_rbg;
  logic                        out_valid;
  logic                        out_ready;
  logic [RBG_SIZE-1:0]         out_rbg;
  logic [TAG_WIDTH-1:0]        out_tag;
  logic [SRC_W-1:0]            out_src;

  // Arbiter side.
  modport master (
    input  req_valid, req_iter, req_tag, lut_rbg, out_ready,
    output req_ready, lut_iter, out_valid, out_rbg, out_tag, out_src
  );

  // Engines, lookup table and downstream consumer side.
  modport slave (
    output req_valid, req_iter, req_tag, lut_rbg, out_ready,
    input  req_ready, lut_iter, out_valid, out_rbg, out_tag, out_src
  );

endinterface

// File: rtl/lut_arbiter_rr_arbiter.sv
// N-way arbiter: request vector + enable -> one-hot grant and index.
// Round-robin by default; LUT_ARB_FIXED_PRIO_EN selects lowest-index-wins.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_en,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [N-1:0]     w_gnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;

`ifdef LUT_ARB_FIXED_PRIO_EN

  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i_en && !w_any && i_req[k]) begin
        w_any    = 1'b1;
        w_gnt[k] = 1'b1;
        w_idx    = IDX_W'(k);
      end
    end
  end

`else

  logic [IDX_W-1:0] r_ptr;

  // Search starts at r_ptr and wraps, so the last winner drops to lowest priority.
  always_comb begin
    int j;
    j     = 0;
    w_gnt = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (i_en && !w_any && i_req[j]) begin
        w_any    = 1'b1;
        w_gnt[j] = 1'b1;
        w_idx    = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

`endif

  assign o_gnt = w_gnt;
  assign o_idx = w_idx;
  assign o_any = w_any;

endmodule

// File: rtl/lut_arbiter.sv
// Shares one combinational colour LUT among N_REQ iteration engines and registers
// the coloured pixel into a one-entry valid/ready stage. Option: LUT_ARB_FIXED_PRIO_EN.
module lut_arbiter
  import lut_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int RBG_SIZE      = 24,
  parameter int MAX_ITERATION = 256,
  parameter int TAG_WIDTH     = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  lut_arbiter_if.master bus
);

  localparam int SRC_W = $clog2(N_REQ);

  logic                  w_accept_p0;
  logic                  w_en_p0;
  logic [N_REQ-1:0]      w_gnt_p0;
  logic [SRC_W-1:0]      w_idx_p0;
  logic                  w_any_p0;
  logic [DATA_WIDTH-1:0] w_iter_p0;
  logic [TAG_WIDTH-1:0]  w_tag_p0;
  logic                  w_inside_p0;
  logic [RBG_SIZE-1:0]   w_rbg_p0;

  logic                  r_vld_p1;
  logic [RBG_SIZE-1:0]   r_rbg_p1;
  logic [TAG_WIDTH-1:0]  r_tag_p1;
  logic [SRC_W-1:0]      r_src_p1;

  // Stage p0: grant, engine select and colour lookup, all combinational.
  assign w_accept_p0 = !r_vld_p1 || bus.out_ready;
  assign w_en_p0     = w_accept_p0 && rst_n;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (bus.req_valid),
    .i_en  (w_en_p0),
    .o_gnt (w_gnt_p0),
    .o_idx (w_idx_p0),
    .o_any (w_any_p0)
  );

  always_comb begin
    w_iter_p0 = '0;
    w_tag_p0  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_p0[i]) begin
        w_iter_p0 = bus.req_iter[i*DATA_WIDTH +: DATA_WIDTH];
        w_tag_p0  = bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  assign w_inside_p0 = clamp_inside(64'(w_iter_p0), 64'(MAX_ITERATION));
  assign w_rbg_p0    = w_inside_p0 ? RBG_SIZE'(RGB_BLACK) : bus.lut_rbg;

  assign bus.req_ready = w_gnt_p0;
  assign bus.lut_iter  = w_iter_p0;

  // Stage p1: one-entry output register; loads on grant, drains on out_ready otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_rbg_p1 <= '0;
      r_tag_p1 <= '0;
      r_src_p1 <= '0;
    end else if (w_any_p0) begin
      r_vld_p1 <= 1'b1;
      r_rbg_p1 <= w_rbg_p0;
      r_tag_p1 <= w_tag_p0;
      r_src_p1 <= w_idx_p0;
    end else if (bus.out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign bus.out_valid = r_vld_p1;
  assign bus.out_rbg   = r_rbg_p1;
  assign bus.out_tag   = r_tag_p1;
  assign bus.out_src   = r_src_p1;

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready));

  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (r_vld_p1 && !bus.out_ready) |=>
      ($stable(r_rbg_p1) && $stable(r_tag_p1) && $stable(r_src_p1)));

endmodule

// File: doc/lut_arbiter.md
Name: lut_arbiter

Overview:
- Shares the single combinational colour lookup table (iteration count -> 24-bit RBG) between N_REQ Mandelbrot iteration engines.
- Each cycle, grants one engine round-robin, drives the lookup address from that engine, and registers the colour, pixel tag and source index into a one-entry output stage.
- The output stage is a valid/ready stream feeding the pixel packer / video-out path.

Parameters:
- N_REQ, 4, number of iteration engines (2..8)
- DATA_WIDTH, 32, width of iteration count and of the lookup-table address
- RBG_SIZE, 24, colour width
- MAX_ITERATION, 256, lookup-table depth; iteration counts >= this are "inside set"
- TAG_WIDTH, 20, pixel tag width (raster index)
- SRC_W, $clog2(N_REQ), source index width (derived localparam)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  N_REQ  engine i has a finished pixel
- req_ready  out  N_REQ  engine i's pixel accepted this cycle (one-hot or zero)
- req_iter  in  N_REQ*DATA_WIDTH  packed iteration counts; engine i occupies slice i
- req_tag  in  N_REQ*TAG_WIDTH  packed pixel tags
- lut_iter  out  DATA_WIDTH  address to the shared colour lookup table
- lut_rbg  in  RBG_SIZE  lookup-table data, combinational from lut_iter
- out_valid  out  1  output stage holds a colour
- out_ready  in  1  downstream accepts
- out_rbg  out  RBG_SIZE  colour
- out_tag  out  TAG_WIDTH  pixel tag
- out_src  out  SRC_W  granting engine index

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values: out_valid=0, out_rbg=0, out_tag=0, out_src=0, rr_ptr=0. req_ready=0 during reset.
- Reset mid-operation: any held output is discarded with no handshake; engines must re-present.
- accept = !out_valid || out_ready. The output stage can load in the same cycle it drains (full throughput, 1 pixel/cycle).
- Grant (combinational): when accept=1, pick the first i with req_valid[i]=1, searching from rr_ptr upward modulo N_REQ.
  - req_ready[i]=1 only for the winner.
  - If accept=0 or no request is valid, req_ready is all 0.
- rr_ptr update: after a grant to g, rr_ptr <= (g+1) mod N_REQ. Otherwise unchanged.
- lut_iter is always the winner's req_iter, or 0 when there is no grant. It is combinational, with no register before the lookup table.
- Colour rule:
  - if granted req_iter >= MAX_ITERATION, the loaded colour is 0 (black) and lut_rbg is ignored;
  - otherwise the loaded colour is lut_rbg. The comparison is unsigned, full DATA_WIDTH.
- Latency: the request handshake in cycle t gives out_valid=1 with the data in cycle t+1.
- Output stability: while out_valid=1 and out_ready=0, out_rbg/out_tag/out_src hold.
- Output drain: the stage clears when out_ready=1 and no new grant is made.
- Inputs: requesters may drop req_valid without a handshake; the arbiter does not latch requests.
- State: two-state view of the output stage, EMPTY and FULL.
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on out_ready with no grant.
  - FULL -> FULL on out_ready with a grant, or on a stall.
- Assertions: req_ready is one-hot-or-zero; out_* are stable under stall.

Optional Feature:
- Macro: LUT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest index wins; rr_ptr is removed, and higher-index engines can starve under saturation.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

Decomposition:
- Package lut_arb_pkg:
  - typedef rgb_t (logic [23:0]);
  - localparam RGB_BLACK = 24'h000000;
  - function clamp_inside(iter, max) returning the inside-set flag.
- Sub-module rr_arbiter (N-way, req vector + enable -> one-hot grant + index; holds rr_ptr).
  - The fixed-priority variant is selected inside it by the macro.
- lut_arbiter instantiates rr_arbiter.
- The lookup table itself stays outside this block.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all req_valid=1 -> req_ready=0, out_valid=0, out_rbg=0 throughout; the first grant after release goes to engine 0.
- Round-robin fairness: N_REQ=4, all valid continuously, out_ready=1 -> grant order 0,1,2,3,0,1; out_src follows one cycle later; one output per cycle.
- Backpressure: the output is loaded with tag 0x00005; hold out_ready=0 for 5 cycles with engines valid -> req_ready=0, out_tag stays 0x00005. When out_ready rises, the same cycle grants the next engine and out_valid stays 1.
- Inside-set clamp: req_iter=256 (=MAX_ITERATION) on engine 2 with the lookup table returning 0xFF00FF -> out_rbg=0x000000, out_src=2.
- Lookup path: req_iter=17 -> lut_iter=17 in the grant cycle; out_rbg equals the lookup table's word 17 in the next cycle.
- Sparse/idle: only engine 3 valid, pulsed every other cycle -> each pulse granted; out_valid drops between pulses when out_ready=1; rr_ptr wraps to 0 after grant 3.
